mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Multicycle MIPS control FSM. Sequences one shared ALU, register file and unified instruction/data memory across FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK cycles.
- Replaces the single-cycle main decoder in the multicycle datapath.
- Uses the same opcode set and 4-bit aluop encoding as the single-cycle decoder.
- Adds a memory ready handshake with a wait timeout.

Parameters:
- WAIT_LIMIT, 15: maximum consecutive cycles a memory state waits for mem_ready before abort; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- op  input  6  opcode from instruction register (op_t)
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the access this cycle
- mem_req  output  1  memory access request
- memwrite  output  1  memory write strobe
- iord  output  1  0 = PC address, 1 = ALUOut address
- irwrite  output  1  load instruction register
- regwrite  output  1  register file write
- regdst  output  1  1 = rd, 0 = rt
- memtoreg  output  1  1 = data register, 0 = ALUOut
- alusrca  output  1  0 = PC, 1 = A
- alusrcb  output  2  00 = B, 01 = 4, 10 = imm, 11 = imm<<2
- pcsrc  output  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
- pcen  output  1  equals pcwrite | (branch & zero)
- zeroextend  output  1  zero-extend immediate
- aluop  output  4  ALU operation code
- illegal_op  output  1  one-cycle pulse on an unsupported opcode
- mem_timeout  output  1  one-cycle pulse on a memory wait abort
- state_o  output  4  current state, for debug

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset: state becomes FETCH and the wait counter clears. With reset asserted, all outputs are 0, including aluop = 0000 and state_o = FETCH = 0.
- Outputs are Moore-decoded from the state. Exception: irwrite, pcen and memwrite are qualified by mem_ready in memory states.
- State codes: FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, RTYPEEX = 6, RTYPEWB = 7, BEQEX = 8, IEX = 9, IWB = 10, JEX = 11.
- FETCH:
  - Drives mem_req = 1, iord = 0, alusrca = 0, alusrcb = 01, aluop = 0000, pcsrc = 00.
  - While mem_ready = 0: hold the state; irwrite and pcen stay 0.
  - When mem_ready = 1: irwrite = 1, pcen = 1, go to DECODE.
- DECODE: alusrca = 0, alusrcb = 11, aluop = 0000. Branch on op:
  - 0 -> RTYPEEX
  - 2 -> JEX
  - 4 -> BEQEX
  - 35 or 43 -> MEMADR
  - 8, 9, 10, 12, 13, 14, 15 -> IEX
  - any other opcode -> FETCH, with illegal_op = 1 for that cycle.
- MEMADR: alusrca = 1, alusrcb = 10, aluop = 0000. op = 35 -> MEMRD, else -> MEMWR.
- MEMRD: mem_req = 1, iord = 1. On mem_ready -> MEMWB.
- MEMWB: regwrite = 1, regdst = 0, memtoreg = 1 -> FETCH.
- MEMWR: mem_req = 1, iord = 1, memwrite = mem_ready. On mem_ready -> FETCH.
- RTYPEEX: alusrca = 1, alusrcb = 00, aluop = 1111 -> RTYPEWB.
- RTYPEWB: regwrite = 1, regdst = 1, memtoreg = 0 -> FETCH.
- BEQEX:
  - alusrca = 1, alusrcb = 00, aluop = 0001, pcsrc = 01, branch = 1 -> FETCH.
  - pcen = zero.
- IEX:
  - alusrca = 1, alusrcb = 10 -> IWB.
  - aluop by opcode: 8 and 9 -> 0000; 10 -> 0010; 12 -> 0100; 13 -> 0101; 14 -> 0110; 15 -> 0111.
  - zeroextend = 1 for op 12..15, else 0.
- IWB: regwrite = 1, regdst = 0, memtoreg = 0, with the IEX aluop and zeroextend held -> FETCH.
- JEX: pcsrc = 10, pcen = 1 -> FETCH.
- Opcode handling: op is sampled live in each state; the IR is stable after DECODE.
- Latency, assuming mem_ready is 1 on the first request cycle:
  - lw = 5 cycles
  - sw, R-type and immediate ops = 4 cycles
  - beq and j = 3 cycles
- Wait counter:
  - Counts cycles spent in FETCH, MEMRD or MEMWR with mem_ready = 0.
  - Clears on any state change.
  - On reaching WAIT_LIMIT: mem_timeout pulses, mem_req drops the next cycle, state goes to FETCH, and no register, PC or memory write occurs.
- mem_ready arriving in the same cycle as the limit is hit: the completion wins and there is no timeout.
- mem_ready outside the memory states is ignored.
- reset overrides all events, including mid-instruction and mid-wait.

Optional Feature:
- Macro: MC_CTRL_PERFCNT_EN.
- When defined, adds two outputs:
  - instr_count [31:0]: increments on each transition back to FETCH from MEMWB, MEMWR, RTYPEWB, BEQEX, IWB or JEX.
  - stall_count [31:0]: increments every cycle mem_req = 1 and mem_ready = 0.
  - Both clear on reset and wrap modulo 2^32.
- When undefined, neither port nor their logic exists.

Test Plan:
- reset held 3 cycles mid-MEMRD -> next cycle state_o = 0, all outputs 0, wait counter cleared.
- op = 35 with mem_ready tied to 1 -> states 0, 1, 2, 3, 4, 0; regwrite and memtoreg = 1 only in state 4; 5 cycles total.
- op = 4 with zero = 1, then op = 4 with zero = 0 -> pcen = 1 in BEQEX only for the zero = 1 case; aluop = 0001.
- op = 13 -> IEX/IWB with aluop = 0101, zeroextend = 1; op = 8 -> aluop = 0000, zeroextend = 0.
- op = 43 with mem_ready low for 15 cycles (WAIT_LIMIT = 15) -> mem_timeout pulse, memwrite never 1, return to FETCH. Repeat with mem_ready rising on cycle 15 -> memwrite = 1 and no timeout.
- op = 6'd5 -> illegal_op pulses in DECODE, next state FETCH, no regwrite; with MC_CTRL_PERFCNT_EN defined, instr_count is unchanged.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM with memory ready handshake and wait timeout.
// Optional performance counters are enabled by defining MC_CTRL_PERFCNT_EN.
module mc_controller #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       zeroextend,
  output logic [3:0] aluop,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state_o
`ifdef MC_CTRL_PERFCNT_EN
  ,
  output logic [31:0] instr_count,
  output logic [31:0] stall_count
`endif
);

  localparam int unsigned WAIT_W = 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_IEX     = 4'd9,
    S_IWB     = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              abort_q, abort_d;
  logic              pcwrite, branch, waiting;

  function automatic logic [3:0] imm_aluop(input logic [5:0] opc);
    case (opc)
      6'd10:   return 4'b0010;
      6'd12:   return 4'b0100;
      6'd13:   return 4'b0101;
      6'd14:   return 4'b0110;
      6'd15:   return 4'b0111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic imm_zext(input logic [5:0] opc);
    return (opc >= 6'd12) && (opc <= 6'd15);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    abort_d     = 1'b0;
    mem_req     = 1'b0;
    memwrite    = 1'b0;
    iord        = 1'b0;
    irwrite     = 1'b0;
    regwrite    = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    pcsrc       = 2'b00;
    zeroextend  = 1'b0;
    aluop       = 4'b0000;
    illegal_op  = 1'b0;
    mem_timeout = 1'b0;
    pcwrite     = 1'b0;
    branch      = 1'b0;
    waiting     = 1'b0;

    case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01;
        // After a timeout, FETCH idles one cycle with mem_req low so memory can cancel
        if (!abort_q) begin
          mem_req = 1'b1;
          if (mem_ready) begin
            irwrite = 1'b1;
            pcwrite = 1'b1;
            state_d = S_DECODE;
          end else begin
            waiting = 1'b1;
          end
        end
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          6'd0:         state_d = S_RTYPEEX;
          6'd2:         state_d = S_JEX;
          6'd4:         state_d = S_BEQEX;
          6'd35, 6'd43: state_d = S_MEMADR;
          6'd8, 6'd9, 6'd10, 6'd12, 6'd13, 6'd14, 6'd15: state_d = S_IEX;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == 6'd35) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
        else           waiting = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        memwrite = mem_ready;
        if (mem_ready) state_d = S_FETCH;
        else           waiting = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 4'b1111;
        state_d = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = 4'b0001;
        pcsrc   = 2'b01;
        branch  = 1'b1;
        state_d = S_FETCH;
      end
      S_IEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        aluop      = imm_aluop(op);
        zeroextend = imm_zext(op);
        state_d    = S_IWB;
      end
      S_IWB: begin
        regwrite   = 1'b1;
        aluop      = imm_aluop(op);
        zeroextend = imm_zext(op);
        state_d    = S_FETCH;
      end
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // A stalled access that reaches the limit aborts; a same-cycle completion never gets here
    if (waiting) begin
      if (wait_q == WAIT_LAST) begin
        mem_timeout = 1'b1;
        abort_d     = 1'b1;
        state_d     = S_FETCH;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end
    if ((state_d != state_q) || mem_timeout) wait_d = '0;

    pcen    = pcwrite | (branch & zero);
    state_o = state_q;

    if (reset) begin
      mem_req     = 1'b0;
      memwrite    = 1'b0;
      iord        = 1'b0;
      irwrite     = 1'b0;
      regwrite    = 1'b0;
      regdst      = 1'b0;
      memtoreg    = 1'b0;
      alusrca     = 1'b0;
      alusrcb     = 2'b00;
      pcsrc       = 2'b00;
      pcen        = 1'b0;
      zeroextend  = 1'b0;
      aluop       = 4'b0000;
      illegal_op  = 1'b0;
      mem_timeout = 1'b0;
      state_o     = 4'd0;
    end
  end

`ifdef MC_CTRL_PERFCNT_EN
  logic [31:0] instr_q, instr_d, stall_q, stall_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= '0;
      stall_q <= '0;
    end else begin
      instr_q <= instr_d;
      stall_q <= stall_d;
    end
  end

  // Retirement = a completed final state returning to FETCH
  always_comb begin
    instr_d = instr_q;
    stall_d = stall_q;
    if ((state_d == S_FETCH) && !mem_timeout &&
        (state_q inside {S_MEMWB, S_MEMWR, S_RTYPEWB, S_BEQEX, S_IWB, S_JEX}))
      instr_d = instr_q + 32'd1;
    if (mem_req && !mem_ready) stall_d = stall_q + 32'd1;
  end

  assign instr_count = instr_q;
  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: directed then random instructions checked
// every cycle against an instruction-level reference model.
module tb_mc_controller;

  localparam int unsigned WAIT_LIMIT = 15;
  localparam int NCYC = 4000;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, memwrite, iord, irwrite, regwrite, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       pcen, zeroextend, illegal_op, mem_timeout;
  logic [3:0] aluop, state_o;

  mc_controller #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
    .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .pcen(pcen), .zeroextend(zeroextend),
    .aluop(aluop), .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op;
    logic       zero;
    bit         rnd;
    int         f_stall;
    int         d_stall;
    int         rst_cyc;
  } instr_t;

  instr_t      directed[$];
  logic [23:0] exp_q[$];
  int          checks;
  int          failures;

  // Reference model: current step, pending steps of the instruction, wait count, abort bubble
  int m_st;
  int m_wait;
  bit m_abort;
  int m_plan[$];

  function automatic instr_t mk(logic [5:0] o, logic z, int fs, int ds, int rc);
    instr_t d;
    d.op = o; d.zero = z; d.rnd = 1'b0; d.f_stall = fs; d.d_stall = ds; d.rst_cyc = rc;
    return d;
  endfunction

  function automatic bit is_legal(logic [5:0] o);
    return o inside {6'd0, 6'd2, 6'd4, 6'd8, 6'd9, 6'd10, 6'd12, 6'd13, 6'd14, 6'd15, 6'd35, 6'd43};
  endfunction

  function automatic logic [3:0] imm_op(logic [5:0] o);
    logic [3:0] t;
    t = 4'b0000;
    if (o == 6'd10) t = 4'b0010;
    if (o >= 6'd12 && o <= 6'd15) t = 4'(32'd4 + 32'(o) - 32'd12);
    return t;
  endfunction

  // Steps taken after DECODE for each instruction class
  function automatic void load_plan(logic [5:0] o);
    m_plan.delete();
    if (o == 6'd35) begin m_plan.push_back(2); m_plan.push_back(3); m_plan.push_back(4); end
    else if (o == 6'd43) begin m_plan.push_back(2); m_plan.push_back(5); end
    else if (o == 6'd0) begin m_plan.push_back(6); m_plan.push_back(7); end
    else if (o == 6'd4) m_plan.push_back(8);
    else if (o == 6'd2) m_plan.push_back(11);
    else if (is_legal(o)) begin m_plan.push_back(9); m_plan.push_back(10); end
  endfunction

  function automatic bit is_mem_step(int st, bit ab);
    return (st == 0 && !ab) || st == 3 || st == 5;
  endfunction

  function automatic logic [23:0] expect_out(int st, logic [5:0] o, logic z, logic rdy, int w, bit ab);
    logic       mreq, mw, io, irw, rw, rd, m2r, asa, pce, ze, ill, to;
    logic [1:0] asb, pcs;
    logic [3:0] aop;
    {mreq, mw, io, irw, rw, rd, m2r, asa, pce, ze, ill} = '0;
    asb = 2'b00; pcs = 2'b00; aop = 4'b0000;
    to = is_mem_step(st, ab) && !rdy && (w + 1 == int'(WAIT_LIMIT));
    case (st)
      0: begin asb = 2'b01; if (!ab) begin mreq = 1'b1; irw = rdy; pce = rdy; end end
      1: begin asb = 2'b11; ill = !is_legal(o); end
      2: begin asa = 1'b1; asb = 2'b10; end
      3: begin mreq = 1'b1; io = 1'b1; end
      4: begin rw = 1'b1; m2r = 1'b1; end
      5: begin mreq = 1'b1; io = 1'b1; mw = rdy; end
      6: begin asa = 1'b1; aop = 4'b1111; end
      7: begin rw = 1'b1; rd = 1'b1; end
      8: begin asa = 1'b1; aop = 4'b0001; pcs = 2'b01; pce = z; end
      9: begin asa = 1'b1; asb = 2'b10; aop = imm_op(o); ze = (o >= 6'd12 && o <= 6'd15); end
      10: begin rw = 1'b1; aop = imm_op(o); ze = (o >= 6'd12 && o <= 6'd15); end
      11: begin pcs = 2'b10; pce = 1'b1; end
      default: ;
    endcase
    return {4'(st), mreq, mw, io, irw, rw, rd, m2r, asa, asb, pcs, pce, ze, aop, ill, to};
  endfunction

  task automatic model_step(input logic rst, input logic [5:0] o, input logic rdy, output bit done);
    done = 1'b0;
    if (rst) begin
      m_st = 0; m_wait = 0; m_abort = 1'b0; m_plan.delete(); done = 1'b1;
    end else if (m_st == 0 && m_abort) begin
      m_abort = 1'b0;
    end else if (is_mem_step(m_st, m_abort) && !rdy) begin
      if (m_wait + 1 == int'(WAIT_LIMIT)) begin
        m_st = 0; m_wait = 0; m_abort = 1'b1; m_plan.delete(); done = 1'b1;
      end else begin
        m_wait++;
      end
    end else begin
      m_wait = 0;
      if (m_st == 0) m_st = 1;
      else if (m_st == 1) begin
        load_plan(o);
        if (m_plan.size() == 0) begin m_st = 0; done = 1'b1; end
        else m_st = m_plan.pop_front();
      end else if (m_plan.size() > 0) m_st = m_plan.pop_front();
      else begin m_st = 0; done = 1'b1; end
    end
  endtask

  // Monitor: every cycle the DUT presents a full control word
  initial begin
    logic [23:0] e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {state_o, mem_req, memwrite, iord, irwrite, regwrite, regdst, memtoreg, alusrca,
             alusrcb, pcsrc, pcen, zeroextend, aluop, illegal_op, mem_timeout};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL ctrl_word t=%0t got=%h expected=%h", $time, a, e);
        end
      end
    end
  end

  // Driver
  initial begin
    instr_t cur;
    bit     need_new, cur_dir, done, r;
    int     cyc_in, rst_left, tgt;
    logic   rdy;
    logic [5:0] pool [13];
    int     fs_pool [7];
    int     ds_pool [7];
    pool = '{6'd0, 6'd2, 6'd4, 6'd8, 6'd9, 6'd10, 6'd12, 6'd13, 6'd14, 6'd15, 6'd35, 6'd43, 6'd5};
    fs_pool = '{0, 0, 0, 1, 5, 14, 15};
    ds_pool = '{0, 0, 2, 13, 14, 15, 20};

    checks = 0; failures = 0;
    m_st = 0; m_wait = 0; m_abort = 1'b0;
    reset = 1'b1; op = '0; zero = 1'b0; mem_ready = 1'b0;

    directed.push_back(mk(6'd35, 1'b0, 0, 0, -1));
    directed.push_back(mk(6'd4, 1'b1, 0, 0, -1));
    directed.push_back(mk(6'd4, 1'b0, 0, 0, -1));
    directed.push_back(mk(6'd13, 1'b0, 0, 0, -1));
    directed.push_back(mk(6'd8, 1'b0, 0, 0, -1));
    directed.push_back(mk(6'd43, 1'b0, 0, 15, -1));
    directed.push_back(mk(6'd43, 1'b0, 0, 14, -1));
    directed.push_back(mk(6'd5, 1'b0, 0, 0, -1));
    directed.push_back(mk(6'd35, 1'b0, 0, 100, 5));
    directed.push_back(mk(6'd35, 1'b0, 15, 0, -1));
    directed.push_back(mk(6'd0, 1'b0, 0, 0, -1));
    directed.push_back(mk(6'd2, 1'b0, 0, 0, -1));
    directed.push_back(mk(6'd43, 1'b0, 14, 0, -1));

    cur = mk(6'd0, 1'b0, 0, 0, -1);
    cur_dir = 1'b0;
    need_new = 1'b1;
    cyc_in = 0;
    rst_left = 3;

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      if (need_new && rst_left == 0) begin
        if (directed.size() > 0) begin
          cur = directed.pop_front();
          cur_dir = 1'b1;
        end else begin
          cur = mk($urandom_range(0, 4) == 0 ? 6'($urandom) : pool[$urandom_range(0, 12)],
                   1'($urandom), fs_pool[$urandom_range(0, 6)], ds_pool[$urandom_range(0, 6)], -1);
          cur.rnd = ($urandom_range(0, 2) == 0);
          cur_dir = 1'b0;
        end
        need_new = 1'b0;
        cyc_in = 0;
      end

      if (rst_left == 0 && cur.rst_cyc == cyc_in) rst_left = 3;
      else if (rst_left == 0 && !cur_dir && $urandom_range(0, 299) == 0) rst_left = $urandom_range(1, 3);
      r = (rst_left > 0);
      if (rst_left > 0) rst_left--;

      if (is_mem_step(m_st, m_abort)) begin
        if (cur.rnd) rdy = ($urandom_range(0, 3) != 0);
        else begin
          tgt = (m_st == 0) ? cur.f_stall : cur.d_stall;
          rdy = (m_wait >= tgt);
        end
      end else begin
        rdy = 1'($urandom);
      end

      reset = r; op = cur.op; zero = cur.zero; mem_ready = rdy;
      exp_q.push_back(r ? 24'h0 : expect_out(m_st, cur.op, cur.zero, rdy, m_wait, m_abort));
      model_step(r, cur.op, rdy, done);
      if (done) need_new = 1'b1;
      cyc_in++;
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
